execute_pipe: RTL and testbench

- Parametrised, registered execute stage between decode (ID) and memory (MEM).
- Single-cycle ALU ops, an iterative multiplier, branch/jump resolution, link writes and load/store address generation.
- Valid/ready handshakes on both sides; a one-cycle redirect pulse to fetch.

---
 rtl/execute_pipe_if.sv | 64 ++++++
 rtl/execute_pipe.sv | 258 +++++++++++++++++++++++++
 tb/tb_execute_pipe.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : execute_pipe_if
// Purpose  : ID -> EX -> MEM handshake bundle plus redirect and status lines
// Revision : 1.0  initial release
// ============================================================================
interface execute_pipe_if #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3
);
  // decode side
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [DATA_W-1:0]    in_rs;
  logic [DATA_W-1:0]    in_rt;
  logic [DATA_W-1:0]    in_rd;
  logic [DATA_W-1:0]    in_pc_nxt;
  logic [DATA_W-1:0]    in_target;
  logic [REG_IDX_W-1:0] in_dest;
  logic                 in_reg_wr;
  logic                 in_link;
  logic                 in_ldst;
  logic [1:0]           in_store;
  logic                 in_branch;
  logic [1:0]           in_br_cond;
  logic                 in_jmp;
  logic                 in_jmp_reg;
  // memory side
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_result;
  logic [DATA_W-1:0]    out_mem_addr;
  logic [DATA_W-1:0]    out_mem_data;
  logic [REG_IDX_W-1:0] out_dest;
  logic                 out_reg_wr;
  logic                 out_ldst;
  logic [1:0]           out_store;
  // fetch redirect and status
  logic                 redirect_valid;
  logic [DATA_W-1:0]    redirect_target;
  logic                 busy;

  modport master (
    output flush, in_valid, in_op, in_rs, in_rt, in_rd, in_pc_nxt, in_target,
           in_dest, in_reg_wr, in_link, in_ldst, in_store, in_branch,
           in_br_cond, in_jmp, in_jmp_reg, out_ready,
    input  in_ready, out_valid, out_result, out_mem_addr, out_mem_data,
           out_dest, out_reg_wr, out_ldst, out_store, redirect_valid,
           redirect_target, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs, in_rt, in_rd, in_pc_nxt, in_target,
           in_dest, in_reg_wr, in_link, in_ldst, in_store, in_branch,
           in_br_cond, in_jmp, in_jmp_reg, out_ready,
    output in_ready, out_valid, out_result, out_mem_addr, out_mem_data,
           out_dest, out_reg_wr, out_ldst, out_store, redirect_valid,
           redirect_target, busy
  );
endinterface
`default_nettype wire

// File: rtl/execute_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : execute_pipe
// Purpose  : registered execute stage: single-cycle ALU, iterative shift-add
//            multiplier, branch/jump resolution and address generation
// Revision : 1.0  initial release
// ============================================================================
module execute_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int MUL_STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  execute_pipe_if.slave bus
);
  localparam int ITER  = DATA_W / MUL_STEP;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    acc;
  logic [DATA_W-1:0]    mcand;
  logic [DATA_W-1:0]    mplier;

  // side information of the multiply in flight, replayed when it completes
  logic [DATA_W-1:0]    m_rd;
  logic [DATA_W-1:0]    m_pc_nxt;
  logic [DATA_W-1:0]    m_target;
  logic [REG_IDX_W-1:0] m_dest;
  logic                 m_reg_wr;
  logic                 m_ldst;
  logic                 m_link;
  logic                 m_taken;
  logic [1:0]           m_store;

  logic                 ready;
  logic                 accept;
  logic                 is_mul;
  logic                 last;
  logic [SH_W-1:0]      sh;
  logic [2*DATA_W-1:0]  rol_wide;
  logic [2*DATA_W-1:0]  ror_wide;
  logic [DATA_W-1:0]    alu;
  logic                 cond_true;
  logic                 taken_in;
  logic [DATA_W-1:0]    target_in;
  logic [DATA_W-1:0]    step_sum;
  logic [DATA_W-1:0]    acc_nxt;

  logic                 load_en;
  logic [DATA_W-1:0]    ld_result;
  logic [DATA_W-1:0]    ld_addr;
  logic [DATA_W-1:0]    ld_data;
  logic [REG_IDX_W-1:0] ld_dest;
  logic                 ld_reg_wr;
  logic                 ld_ldst;
  logic [1:0]           ld_store;
  logic                 ld_taken;
  logic [DATA_W-1:0]    ld_target;

  // a new instruction enters only when idle, the output slot frees up and
  // no flush is killing the pipe
  assign ready        = (state == S_IDLE) & (!bus.out_valid | bus.out_ready) & !bus.flush;
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign is_mul       = (bus.in_op == OP_MUL);
  assign last         = (cnt == CNT_W'(ITER - 1));
  assign bus.busy     = (state == S_MUL);

  // rotates come from the upper/lower half of a doubled operand
  assign sh       = bus.in_rt[SH_W-1:0];
  assign rol_wide = {bus.in_rs, bus.in_rs} << sh;
  assign ror_wide = {bus.in_rs, bus.in_rs} >> sh;

  // single-cycle ALU; unused encodings (and MUL here) fall back to ADD
  always_comb begin
    alu = bus.in_rs + bus.in_rt;
    case (bus.in_op)
      OP_SUB:  alu = bus.in_rs - bus.in_rt;
      OP_AND:  alu = bus.in_rs & bus.in_rt;
      OP_XOR:  alu = bus.in_rs ^ bus.in_rt;
      OP_SLL:  alu = bus.in_rs << sh;
      OP_SRL:  alu = bus.in_rs >> sh;
      OP_ROL:  alu = rol_wide[2*DATA_W-1:DATA_W];
      OP_ROR:  alu = ror_wide[DATA_W-1:0];
      OP_SEQ:  alu = {{(DATA_W-1){1'b0}}, (bus.in_rs == bus.in_rt)};
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(bus.in_rs) <  $signed(bus.in_rt))};
      OP_SLE:  alu = {{(DATA_W-1){1'b0}}, ($signed(bus.in_rs) <= $signed(bus.in_rt))};
      OP_PASS: alu = bus.in_rt;
      default: alu = bus.in_rs + bus.in_rt;
    endcase
  end

  // branch condition tested against operand A only
  always_comb begin
    case (bus.in_br_cond)
      2'b00:   cond_true = (bus.in_rs == '0);
      2'b01:   cond_true = (bus.in_rs != '0);
      2'b10:   cond_true = bus.in_rs[DATA_W-1];
      default: cond_true = !bus.in_rs[DATA_W-1];
    endcase
  end

  assign taken_in  = bus.in_jmp | bus.in_jmp_reg | (bus.in_branch & cond_true);
  assign target_in = bus.in_jmp_reg ? (bus.in_rs + bus.in_target) : bus.in_target;

  // one shift-add step: add the multiplicand for each of MUL_STEP low multiplier bits
  always_comb begin
    step_sum = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier[k]) begin
        step_sum = step_sum + (mcand << k);
      end
    end
    acc_nxt = acc + step_sum;
  end

  // select what lands in the output registers: a fresh ALU op or a finished multiply
  always_comb begin
    load_en   = 1'b0;
    ld_result = '0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_dest   = '0;
    ld_reg_wr = 1'b0;
    ld_ldst   = 1'b0;
    ld_store  = 2'b00;
    ld_taken  = 1'b0;
    ld_target = '0;
    if (state == S_MUL) begin
      load_en   = last;
      ld_result = m_link ? m_pc_nxt : acc_nxt;
      ld_addr   = acc_nxt;
      ld_data   = m_rd;
      ld_dest   = m_dest;
      ld_reg_wr = m_reg_wr;
      ld_ldst   = m_ldst;
      ld_store  = m_store;
      ld_taken  = m_taken;
      ld_target = m_target;
    end else begin
      load_en   = accept & !is_mul;
      ld_result = bus.in_link ? bus.in_pc_nxt : alu;
      ld_addr   = alu;
      ld_data   = bus.in_rd;
      ld_dest   = bus.in_dest;
      ld_reg_wr = bus.in_reg_wr;
      ld_ldst   = bus.in_ldst;
      ld_store  = bus.in_store;
      ld_taken  = taken_in;
      ld_target = target_in;
    end
  end

  // control FSM, multiplier datapath and registered outputs; flush beats everything but reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      acc                 <= '0;
      mcand               <= '0;
      mplier              <= '0;
      m_rd                <= '0;
      m_pc_nxt            <= '0;
      m_target            <= '0;
      m_dest              <= '0;
      m_reg_wr            <= 1'b0;
      m_ldst              <= 1'b0;
      m_link              <= 1'b0;
      m_taken             <= 1'b0;
      m_store             <= 2'b00;
      bus.out_valid       <= 1'b0;
      bus.out_result      <= '0;
      bus.out_mem_addr    <= '0;
      bus.out_mem_data    <= '0;
      bus.out_dest        <= '0;
      bus.out_reg_wr      <= 1'b0;
      bus.out_ldst        <= 1'b0;
      bus.out_store       <= 2'b00;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_target <= '0;
    end else if (bus.flush) begin
      state              <= S_IDLE;
      cnt                <= '0;
      bus.out_valid      <= 1'b0;
      bus.redirect_valid <= 1'b0;
    end else begin
      bus.redirect_valid <= 1'b0;
      if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            state    <= S_MUL;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= bus.in_rs;
            mplier   <= bus.in_rt;
            m_rd     <= bus.in_rd;
            m_pc_nxt <= bus.in_pc_nxt;
            m_target <= target_in;
            m_dest   <= bus.in_dest;
            m_reg_wr <= bus.in_reg_wr;
            m_ldst   <= bus.in_ldst;
            m_link   <= bus.in_link;
            m_taken  <= taken_in;
            m_store  <= bus.in_store;
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          if (last) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (load_en) begin
        bus.out_valid       <= 1'b1;
        bus.out_result      <= ld_result;
        bus.out_mem_addr    <= ld_addr;
        bus.out_mem_data    <= ld_data;
        bus.out_dest        <= ld_dest;
        bus.out_reg_wr      <= ld_reg_wr;
        bus.out_ldst        <= ld_ldst;
        bus.out_store       <= ld_store;
        bus.redirect_valid  <= ld_taken;
        bus.redirect_target <= ld_target;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_execute_pipe
// Purpose  : self-checking bench for execute_pipe (MUL_STEP 1 and 4 instances)
// Revision : 1.0  initial release
// ============================================================================
module tb_execute_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_pipe_if #(.DATA_W(W), .REG_IDX_W(3)) bus  ();
  execute_pipe_if #(.DATA_W(W), .REG_IDX_W(3)) bus4 ();

  execute_pipe #(.DATA_W(W), .REG_IDX_W(3), .MUL_STEP(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  execute_pipe #(.DATA_W(W), .REG_IDX_W(3), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int          s;
    logic [15:0] r;
    logic [31:0] p;
    s = int'(b[3:0]);
    r = a;
    case (op)
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a ^ b;
      4'd4:  return a << s;
      4'd5:  return a >> s;
      4'd6:  begin repeat (s) r = {r[14:0], r[15]}; return r; end
      4'd7:  begin repeat (s) r = {r[0], r[15:1]};  return r; end
      4'd8:  return (a == b) ? 16'd1 : 16'd0;
      4'd9:  return ($signed(a) <  $signed(b)) ? 16'd1 : 16'd0;
      4'd10: return ($signed(a) <= $signed(b)) ? 16'd1 : 16'd0;
      4'd11: return b;
      4'd12: begin p = {16'd0, a} * {16'd0, b}; return p[15:0]; end
      default: return a + b;
    endcase
  endfunction

  function automatic bit model_cond(input logic [1:0] c, input logic [15:0] rs);
    case (c)
      2'b00:   return rs == 16'd0;
      2'b01:   return rs != 16'd0;
      2'b10:   return $signed(rs) < 0;
      default: return $signed(rs) >= 0;
    endcase
  endfunction

  // ---------------- drive helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_pc_nxt = '0; bus.in_target = '0; bus.in_dest = '0;
    bus.in_reg_wr = 1'b0; bus.in_link = 1'b0; bus.in_ldst = 1'b0; bus.in_store = 2'b00;
    bus.in_branch = 1'b0; bus.in_br_cond = 2'b00; bus.in_jmp = 1'b0; bus.in_jmp_reg = 1'b0;
  endtask

  task automatic idle_in4();
    bus4.in_valid = 1'b0; bus4.in_op = 4'd0; bus4.in_rs = '0; bus4.in_rt = '0;
    bus4.in_rd = '0; bus4.in_pc_nxt = '0; bus4.in_target = '0; bus4.in_dest = '0;
    bus4.in_reg_wr = 1'b0; bus4.in_link = 1'b0; bus4.in_ldst = 1'b0; bus4.in_store = 2'b00;
    bus4.in_branch = 1'b0; bus4.in_br_cond = 2'b00; bus4.in_jmp = 1'b0; bus4.in_jmp_reg = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    idle_in();
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = a; bus.in_rt = b;
    bus.in_reg_wr = 1'b1; bus.in_dest = 3'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_in(); idle_in4();
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus4.flush = 1'b0; bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0 || bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h busy=%b redir=%b expected all 0",
               bus.out_valid, bus.out_result, bus.busy, bus.redirect_valid);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_directed();
    logic [3:0]  ops [12] = '{4'd0, 4'd0, 4'd7, 4'd9, 4'd1, 4'd10, 4'd8, 4'd4, 4'd5, 4'd6, 4'd11, 4'd15};
    logic [15:0] as  [12] = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0005,
                              16'h0003, 16'h0001, 16'h8000, 16'h8001, 16'h1234, 16'h0100};
    logic [15:0] bs  [12] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005,
                              16'h0004, 16'h000F, 16'h000F, 16'h0004, 16'hABCD, 16'h0023};
    logic [15:0] exp [12] = '{16'h8000, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'h0001,
                              16'h0000, 16'h8000, 16'h0001, 16'h0018, 16'hABCD, 16'h0123};
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL alu_pre_valid: got %b expected 0", bus.out_valid);
    end
    for (int i = 0; i < 12; i++) begin
      set_alu(ops[i], as[i], bs[i]);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i] || bus.out_mem_addr !== exp[i]) begin
        errors++;
        $display("FAIL alu_dir[%0d]: valid=%b result=%h addr=%h expected 1/%h", i,
                 bus.out_valid, bus.out_result, bus.out_mem_addr, exp[i]);
      end
    end
    idle_in();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL alu_drain: got valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_alu_random();
    logic [3:0]  op;
    logic [15:0] a, b, pc, rd, want;
    logic [2:0]  dest;
    logic [1:0]  st;
    logic        lnk, ld;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd12) op = 4'd0;
      a = 16'($urandom); b = 16'($urandom); pc = 16'($urandom); rd = 16'($urandom);
      dest = 3'($urandom); st = 2'($urandom); lnk = ($urandom_range(0, 7) == 0); ld = 1'($urandom);
      set_alu(op, a, b);
      bus.in_pc_nxt = pc; bus.in_link = lnk; bus.in_rd = rd; bus.in_dest = dest;
      bus.in_store = st; bus.in_ldst = ld;
      want = lnk ? pc : model_alu(op, a, b);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== want || bus.out_mem_addr !== model_alu(op, a, b) ||
          bus.out_mem_data !== rd || bus.out_dest !== dest || bus.out_store !== st || bus.out_ldst !== ld) begin
        errors++;
        $display("FAIL alu_rand[%0d] op=%0d a=%h b=%h: result=%h addr=%h data=%h dest=%0d expected %h/%h/%h/%0d",
                 i, op, a, b, bus.out_result, bus.out_mem_addr, bus.out_mem_data, bus.out_dest,
                 want, model_alu(op, a, b), rd, dest);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_mul();
    int          bad;
    int          lat;
    logic [15:0] a, b;
    set_alu(4'd12, 16'h0012, 16'h0034);
    step();
    idle_in();
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mul_busy_window: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h03A8 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_0x12x0x34: valid=%b result=%h busy=%b expected 1/03a8/0",
               bus.out_valid, bus.out_result, bus.busy);
    end
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 16'hFFFF : 16'($urandom);
      b = (i == 0) ? 16'hFFFF : 16'($urandom);
      set_alu(4'd12, a, b);
      step();
      idle_in();
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
        step();
        lat++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || lat != 17 || bus.out_result !== model_alu(4'd12, a, b)) begin
        errors++;
        $display("FAIL mul_rand[%0d] %h*%h: result=%h latency=%0d expected %h/17",
                 i, a, b, bus.out_result, lat, model_alu(4'd12, a, b));
      end
    end
    step();
  endtask

  task automatic test_mul_step4();
    int bad;
    logic [15:0] av [2] = '{16'h0012, 16'hFFFF};
    logic [15:0] bv [2] = '{16'h0034, 16'hFFFF};
    for (int t = 0; t < 2; t++) begin
      idle_in4();
      bus4.in_valid = 1'b1; bus4.in_op = 4'd12; bus4.in_rs = av[t]; bus4.in_rt = bv[t]; bus4.in_reg_wr = 1'b1;
      step();
      idle_in4();
      bad = 0;
      for (int c = 1; c <= 4; c++) begin
        if (bus4.busy !== 1'b1 || bus4.out_valid !== 1'b0) bad++;
        step();
      end
      checks++;
      if (bad != 0 || bus4.out_valid !== 1'b1 || bus4.out_result !== model_alu(4'd12, av[t], bv[t])) begin
        errors++;
        $display("FAIL mul4[%0d]: bad=%0d valid=%b result=%h expected 0/1/%h", t, bad,
                 bus4.out_valid, bus4.out_result, model_alu(4'd12, av[t], bv[t]));
      end
      step();
    end
  endtask

  task automatic test_stall();
    set_alu(4'd0, 16'h0010, 16'h0020);
    bus.in_rd = 16'hBEEF; bus.in_dest = 3'd5; bus.in_store = 2'b10; bus.in_ldst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    set_alu(4'd1, 16'h0009, 16'h0004);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0030 || bus.out_mem_addr !== 16'h0030 ||
          bus.out_mem_data !== 16'hBEEF || bus.out_dest !== 3'd5 || bus.out_store !== 2'b10 ||
          bus.out_ldst !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b result=%h data=%h dest=%0d ready=%b expected 1/0030/beef/5/0",
                 c, bus.out_valid, bus.out_result, bus.out_mem_data, bus.out_dest, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0005) begin
      errors++; $display("FAIL stall_b2b_first: valid=%b result=%h expected 1/0005", bus.out_valid, bus.out_result);
    end
    set_alu(4'd3, 16'hF0F0, 16'h0FF0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hFF00) begin
      errors++; $display("FAIL stall_b2b_second: valid=%b result=%h expected 1/ff00", bus.out_valid, bus.out_result);
    end
    idle_in();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_branch();
    logic [15:0] rs, tgt, want_t;
    logic [1:0]  c;
    logic        jr, jp, want;
    // taken branch held under stall
    idle_in();
    bus.in_valid = 1'b1; bus.in_branch = 1'b1; bus.in_br_cond = 2'b01; bus.in_rs = 16'h0005; bus.in_target = 16'h0040;
    bus.out_ready = 1'b0;
    step();
    idle_in();
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_target !== 16'h0040 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL br_taken: redir=%b target=%h valid=%b expected 1/0040/1",
               bus.redirect_valid, bus.redirect_target, bus.out_valid);
    end
    step();
    step();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL br_no_repeat: redir=%b valid=%b expected 0/1", bus.redirect_valid, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    step();
    // not-taken branch
    bus.in_valid = 1'b1; bus.in_branch = 1'b1; bus.in_br_cond = 2'b01; bus.in_rs = 16'h0000; bus.in_target = 16'h0040;
    step();
    idle_in();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL br_not_taken: redir=%b valid=%b expected 0/1", bus.redirect_valid, bus.out_valid);
    end
    // JALR with link
    bus.in_valid = 1'b1; bus.in_jmp_reg = 1'b1; bus.in_link = 1'b1; bus.in_reg_wr = 1'b1;
    bus.in_rs = 16'h0100; bus.in_target = 16'h0004; bus.in_pc_nxt = 16'h0011;
    step();
    idle_in();
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_target !== 16'h0104 || bus.out_result !== 16'h0011) begin
      errors++;
      $display("FAIL jalr: redir=%b target=%h result=%h expected 1/0104/0011",
               bus.redirect_valid, bus.redirect_target, bus.out_result);
    end
    step();
    // random branches and jumps
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 16'h0000;
        1:       rs = 16'h8000;
        2:       rs = 16'h7FFF;
        default: rs = 16'($urandom);
      endcase
      tgt = 16'($urandom); c = 2'($urandom);
      jp = ($urandom_range(0, 5) == 0); jr = ($urandom_range(0, 5) == 0);
      idle_in();
      bus.in_valid = 1'b1; bus.in_branch = 1'b1; bus.in_br_cond = c; bus.in_rs = rs; bus.in_target = tgt;
      bus.in_jmp = jp; bus.in_jmp_reg = jr;
      want   = jp || jr || model_cond(c, rs);
      want_t = jr ? 16'(rs + tgt) : tgt;
      step();
      idle_in();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.redirect_valid !== want || (want && bus.redirect_target !== want_t)) begin
        errors++;
        $display("FAIL br_rand[%0d] cond=%0d rs=%h: redir=%b target=%h expected %b/%h",
                 i, c, rs, bus.redirect_valid, bus.redirect_target, want, want_t);
      end
      step();
    end
  endtask

  task automatic test_flush();
    int bad;
    // flush during MUL iteration 5, with a pending jump redirect
    set_alu(4'd12, 16'h0012, 16'h0034);
    bus.in_jmp = 1'b1; bus.in_target = 16'h0200;
    step();
    idle_in();
    repeat (4) step();
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL flush_mid_state: ready=%b busy=%b expected 0/1", bus.in_ready, bus.busy);
    end
    step();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid_after: busy=%b ready=%b valid=%b redir=%b expected 0/1/0/0",
               bus.busy, bus.in_ready, bus.out_valid, bus.redirect_valid);
    end
    bad = 0;
    repeat (14) begin
      step();
      if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_no_late_result: %0d bad cycles expected 0", bad);
    end
    // flush on the last MUL iteration
    set_alu(4'd12, 16'h0003, 16'h0003);
    step();
    idle_in();
    repeat (15) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_last_iter: valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
    end
    // flush coincident with in_valid
    set_alu(4'd0, 16'h0001, 16'h0001);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_coincident_ready: got %b expected 0", bus.in_ready);
    end
    step();
    bus.flush = 1'b0;
    idle_in();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_coincident_accept: valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    set_alu(4'd0, 16'h1234, 16'h1111);
    step();
    set_alu(4'd12, 16'h0003, 16'h0005);
    step();
    idle_in();
    step();
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.out_result !== 16'h2345) begin
      errors++; $display("FAIL rst_pre: busy=%b result=%h expected 1/2345", bus.busy, bus.out_result);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_result !== 16'h0000 || bus.out_valid !== 1'b0 || bus.out_mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async: busy=%b result=%h valid=%b addr=%h expected 0/0000/0/0000",
               bus.busy, bus.out_result, bus.out_valid, bus.out_mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    set_alu(4'd0, 16'h0002, 16'h0003);
    step();
    idle_in();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0005) begin
      errors++; $display("FAIL rst_recover: valid=%b result=%h expected 1/0005", bus.out_valid, bus.out_result);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_mul();
    test_mul_step4();
    test_stall();
    test_branch();
    test_flush();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
